// File: rtl/gray_scale_pipe.sv
// Grayscale converter for packed {R,G,B} pixels: 2-stage valid/ready pipeline
// with per-frame mode (pass/avg/luma/threshold) and an output frame counter.
module gray_scale_pipe #(
    parameter int unsigned CW       = 4,
    parameter int unsigned MODE_RST = 1,
    parameter int unsigned FCW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [CW-1:0]     cfg_thresh,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3*CW-1:0]   s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3*CW-1:0]   m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic [FCW-1:0]    frame_cnt
);

    localparam int unsigned PW = 3 * CW;
    localparam int unsigned SW = CW + 2;
    localparam int unsigned LW = CW + 8;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_AVG   = 2'd1;
    localparam logic [1:0] MODE_LUMA  = 2'd2;

    logic          en;
    logic          accept;
    logic [CW-1:0] r_c, g_c, b_c;
    logic [SW-1:0] sum_c;
    logic [LW-1:0] luma_c;
    logic [1:0]    px_mode_c;
    logic [CW-1:0] px_thr_c;

    logic [1:0]    mode_q;
    logic [CW-1:0] thr_q;

    logic          st1_valid;
    logic [SW-1:0] st1_sum;
    logic [LW-1:0] st1_luma;
    logic [PW-1:0] st1_raw;
    logic          st1_sof;
    logic          st1_eol;
    logic [1:0]    st1_mode;
    logic [CW-1:0] st1_thr;

    logic [CW-1:0] y_avg_c;
    logic [CW-1:0] y_luma_c;
    logic [PW-1:0] result_c;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;

    assign r_c = s_data[3*CW-1:2*CW];
    assign g_c = s_data[2*CW-1:CW];
    assign b_c = s_data[CW-1:0];

    assign sum_c  = SW'(r_c) + SW'(g_c) + SW'(b_c);
    assign luma_c = LW'(r_c) * LW'(77) + LW'(g_c) * LW'(150) + LW'(b_c) * LW'(29);

    // A sof pixel already uses the configuration it latches.
    assign px_mode_c = s_sof ? cfg_mode   : mode_q;
    assign px_thr_c  = s_sof ? cfg_thresh : thr_q;

    // Per-frame configuration latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'(MODE_RST);
            thr_q  <= '0;
        end else if (accept && s_sof) begin
            mode_q <= cfg_mode;
            thr_q  <= cfg_thresh;
        end
    end

    // Stage 1: partial sums, raw pixel, sideband and the pixel's own mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_valid <= 1'b0;
            st1_sum   <= '0;
            st1_luma  <= '0;
            st1_raw   <= '0;
            st1_sof   <= 1'b0;
            st1_eol   <= 1'b0;
            st1_mode  <= 2'(MODE_RST);
            st1_thr   <= '0;
        end else if (en) begin
            st1_valid <= s_valid;
            if (s_valid) begin
                st1_sum  <= sum_c;
                st1_luma <= luma_c;
                st1_raw  <= s_data;
                st1_sof  <= s_sof;
                st1_eol  <= s_eol;
                st1_mode <= px_mode_c;
                st1_thr  <= px_thr_c;
            end
        end
    end

    // Sum of three components is below 3*2^CW, so a constant divide is exact.
    assign y_avg_c  = CW'(st1_sum / SW'(3));
    assign y_luma_c = st1_luma[LW-1:8];

    always_comb begin
        result_c = st1_raw;
        case (st1_mode)
            MODE_PASS: result_c = st1_raw;
            MODE_AVG:  result_c = {y_avg_c, y_avg_c, y_avg_c};
            MODE_LUMA: result_c = {y_luma_c, y_luma_c, y_luma_c};
            default:   result_c = (y_luma_c >= st1_thr) ? {PW{1'b1}} : '0;
        endcase
    end

    // Stage 2: output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end else if (en) begin
            m_valid <= st1_valid;
            if (st1_valid) begin
                m_data <= result_c;
                m_sof  <= st1_sof;
                m_eol  <= st1_eol;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (m_valid && m_ready && m_sof) begin
            frame_cnt <= frame_cnt + FCW'(1);
        end
    end

endmodule

// File: tb/tb_gray_scale_pipe.sv
// Directed bench for gray_scale_pipe (CW=4): table-driven vectors plus
// backpressure, mid-flight reset and small frame-counter wrap sequences.
module tb_gray_scale_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_thresh;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic        s_sof;
    logic        s_eol;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic [15:0] frame_cnt;

    logic        s_ready2, m_valid2, m_sof2, m_eol2;
    logic [11:0] m_data2;
    logic [1:0]  frame_cnt2;

    always #5 clk = ~clk;

    gray_scale_pipe #(.CW(4), .MODE_RST(1), .FCW(16)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
        .s_eol(s_eol), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .frame_cnt(frame_cnt)
    );

    gray_scale_pipe #(.CW(4), .MODE_RST(1), .FCW(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_sof(s_sof),
        .s_eol(s_eol), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
        .m_sof(m_sof2), .m_eol(m_eol2), .frame_cnt(frame_cnt2)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  thr;
        logic        sof;
        logic        eol;
        logic [11:0] data;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        logic [11:0] data;
        logic        sof;
        logic        eol;
        int          cyc;
        bit          lat;
    } exp_t;

    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    exp_t expq[$];
    logic [11:0] exp_now = '0;
    bit   chk_lat = 1'b0;
    int   fc_model = 0;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    always @(posedge clk) cyc++;

    // Record accepted beats and check every output transfer against them.
    always @(negedge clk) begin
        if (rst) begin
            fc_model = 0;
        end else begin
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("m_data", 32'(m_data), 32'(e.data));
                    check("m_sof", 32'(m_sof), 32'(e.sof));
                    check("m_eol", 32'(m_eol), 32'(e.eol));
                    check("frame_cnt", 32'(frame_cnt), 32'(fc_model));
                    if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
                    if (e.sof) fc_model = fc_model + 1;
                end
            end
            if (s_valid && s_ready) begin
                exp_t e;
                e.data = exp_now; e.sof = s_sof; e.eol = s_eol;
                e.cyc = cyc; e.lat = chk_lat;
                expq.push_back(e);
            end
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input vec_t v);
        int n;
        cfg_mode = v.mode; cfg_thresh = v.thr; s_sof = v.sof; s_eol = v.eol;
        s_data = v.data; exp_now = v.exp; s_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clk); n++;
        end
        check("drain", 32'(expq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [3:0] t, input logic so,
                                input logic eo, input logic [11:0] d, input logic [11:0] x);
        vec_t v;
        v.mode = m; v.thr = t; v.sof = so; v.eol = eo; v.data = d; v.exp = x;
        return v;
    endfunction

    logic [11:0] held_data;
    logic        held_sof, held_eol;
    logic [1:0]  fc2_seq [5];

    initial begin
        tbl[0]  = mk(2'd2, 4'd0, 1'b0, 1'b0, 12'hF00, 12'h555);
        tbl[1]  = mk(2'd2, 4'd0, 1'b0, 1'b0, 12'hFFF, 12'hFFF);
        tbl[2]  = mk(2'd2, 4'd0, 1'b0, 1'b1, 12'h000, 12'h000);
        tbl[3]  = mk(2'd2, 4'd0, 1'b1, 1'b0, 12'hF00, 12'h444);
        tbl[4]  = mk(2'd1, 4'd9, 1'b0, 1'b0, 12'hF84, 12'h999);
        tbl[5]  = mk(2'd3, 4'd0, 1'b0, 1'b1, 12'h0F0, 12'h888);
        tbl[6]  = mk(2'd3, 4'd5, 1'b1, 1'b0, 12'hF00, 12'h000);
        tbl[7]  = mk(2'd0, 4'd0, 1'b0, 1'b0, 12'h0F0, 12'hFFF);
        tbl[8]  = mk(2'd0, 4'd0, 1'b0, 1'b1, 12'hF00, 12'h000);
        tbl[9]  = mk(2'd0, 4'd0, 1'b1, 1'b1, 12'h123, 12'h123);
        tbl[10] = mk(2'd1, 4'd0, 1'b0, 1'b0, 12'hABC, 12'hABC);
        fc2_seq[0] = 2'd1; fc2_seq[1] = 2'd2; fc2_seq[2] = 2'd3;
        fc2_seq[3] = 2'd0; fc2_seq[4] = 2'd1;

        rst = 1'b1; cfg_mode = 2'd0; cfg_thresh = 4'd0; s_valid = 1'b0;
        s_data = '0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_sof", 32'(m_sof), 32'd0);
        check("rst_m_eol", 32'(m_eol), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Streamed table vectors at full rate.
        chk_lat = 1'b1;
        for (int i = 0; i < 11; i++) send(tbl[i]);
        drain();
        check("frame_cnt_after_table", 32'(frame_cnt), 32'd3);
        chk_lat = 1'b0;

        // Backpressure: 3-cycle stall once the first output is valid.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(mk(2'd0, 4'd0, 1'(i == 0), 1'(i == 2 || i == 5),
                            12'(32'h111 * (i + 1)), 12'(32'h111 * (i + 1))));
            end
            begin
                int n;
                n = 0;
                do begin @(negedge clk); n++; end while (!m_valid && n < 50);
                check("stall_wait_valid", 32'(m_valid), 32'd1);
                @(posedge clk); #1;
                m_ready = 1'b0;
                held_data = m_data; held_sof = m_sof; held_eol = m_eol;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_s_ready", 32'(s_ready), 32'd0);
                    check("stall_m_valid", 32'(m_valid), 32'd1);
                    check("stall_m_data", 32'(m_data), 32'(held_data));
                    check("stall_m_sof", 32'(m_sof), 32'(held_sof));
                    check("stall_m_eol", 32'(m_eol), 32'(held_eol));
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        drain();

        // Reset with two luma pixels in flight.
        send(mk(2'd2, 4'd0, 1'b1, 1'b0, 12'hF00, 12'h444));
        cfg_mode = 2'd2; s_sof = 1'b0; s_data = 12'hF00; exp_now = 12'h444; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        expq.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("postrst_idle", 32'(m_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(mk(2'd2, 4'd0, 1'b0, 1'b0, 12'hF00, 12'h555));
        drain();

        // Five single-pixel frames on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) begin
            send(mk(2'd1, 4'd0, 1'b1, 1'b1, 12'h000, 12'h000));
            drain();
            check("frame_cnt_fcw2", 32'(frame_cnt2), 32'(fc2_seq[i]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
